// File: rtl/rgb_to_grayscale_stream_if.sv
// rtl/rgb_to_grayscale_stream_if.sv - byte stream in / luma strobe out bundle
// Purpose: groups the byte handshake and the luma output of the grayscale stage.
// Signals:
//   byte_valid  source -> stage  byte_in carries a valid byte
//   byte_in     source -> stage  8-bit byte, order B,G,R,B,G,R...
//   byte_ready  stage -> source  stage accepts byte_in this cycle
//   grayscale_o stage -> sink    luma of the most recently completed pixel
//   done_o      stage -> sink    one-cycle strobe, grayscale_o valid
interface rgb_to_grayscale_stream_if;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       byte_ready;
  logic [7:0] grayscale_o;
  logic       done_o;

  modport master (
    output byte_valid,
    output byte_in,
    input  byte_ready,
    input  grayscale_o,
    input  done_o
  );

  modport slave (
    input  byte_valid,
    input  byte_in,
    output byte_ready,
    output grayscale_o,
    output done_o
  );
endinterface

// File: rtl/rgb_to_grayscale_stream.sv
// rtl/rgb_to_grayscale_stream.sv - byte-serial BGR to 8-bit luma stream stage
// Purpose: assembles B,G,R bytes into pixels, converts each to luma through a
//   2-stage multiply/add pipeline and strobes one luma byte per pixel; marks
//   the end of a frame after NUM_PIXELS pixels.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   start       one-cycle pulse, begins a frame when idle
//   px          byte handshake in, grayscale_o/done_o out (slave modport)
//   frame_done  one-cycle strobe with the final done_o of a frame
//   busy        high whenever not idle
module rgb_to_grayscale_stream #(
  parameter int NUM_PIXELS = 17066,
  parameter int COEF_R     = 77,
  parameter int COEF_G     = 150,
  parameter int COEF_B     = 29
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  rgb_to_grayscale_stream_if.slave px,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int               CNT_W    = $clog2(NUM_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);
  localparam logic [15:0]      CR       = 16'(COEF_R);
  localparam logic [15:0]      CG       = 16'(COEF_G);
  localparam logic [15:0]      CB       = 16'(COEF_B);

  // Weights summing above 1.0 could overflow the 16-bit luma sum.
  if (COEF_R + COEF_G + COEF_B > 256) begin : g_coef_check
    $error("COEF_R + COEF_G + COEF_B must not exceed 256");
  end
  if (NUM_PIXELS < 1) begin : g_num_check
    $error("NUM_PIXELS must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       g_q, g_d;
  logic             v1_q, v1_d;
  logic [15:0]      pr_q, pr_d;
  logic [15:0]      pg_q, pg_d;
  logic [15:0]      pb_q, pb_d;
  logic [7:0]       gray_q, gray_d;
  logic             done_q, done_d;
  logic             fdone_q, fdone_d;

  logic             accept;
  logic             launch;
  logic [16:0]      sum_w;

  assign accept = (state_q == S_RUN) && px.byte_valid;
  assign launch = accept && (idx_q == 2'd2);
  // +128 rounds to nearest before dropping the 8 fractional bits.
  assign sum_w  = {1'b0, pr_q} + {1'b0, pg_q} + {1'b0, pb_q} + 17'd128;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    g_d     = g_q;
    v1_d    = 1'b0;
    pr_d    = pr_q;
    pg_d    = pg_q;
    pb_d    = pb_q;
    gray_d  = gray_q;
    done_d  = v1_q;
    fdone_d = 1'b0;

    if (accept) begin
      case (idx_q)
        2'd0: begin
          b_d   = px.byte_in;
          idx_d = 2'd1;
        end
        2'd1: begin
          g_d   = px.byte_in;
          idx_d = 2'd2;
        end
        default: idx_d = 2'd0;
      endcase
    end

    // Stage 1: the R byte arrives live, B and G come from their holding registers.
    if (launch) begin
      v1_d  = 1'b1;
      pr_d  = CR * {8'd0, px.byte_in};
      pg_d  = CG * {8'd0, g_q};
      pb_d  = CB * {8'd0, b_q};
      cnt_d = cnt_q + 1'b1;
    end

    // Stage 2. Pixels launch at least 3 cycles apart, so anything in stage 1
    // while flushing is the frame's final pixel.
    if (v1_q) begin
      gray_d = 8'(sum_w >> 8);
    end
    fdone_d = v1_q && (state_q == S_FLUSH);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      end
      S_RUN: begin
        if (launch && (cnt_q == LAST_PIX)) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Stage 1 empty means the last pixel is leaving stage 2 this cycle.
        if (!v1_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      b_q     <= 8'd0;
      g_q     <= 8'd0;
      v1_q    <= 1'b0;
      pr_q    <= 16'd0;
      pg_q    <= 16'd0;
      pb_q    <= 16'd0;
      gray_q  <= 8'd0;
      done_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      g_q     <= g_d;
      v1_q    <= v1_d;
      pr_q    <= pr_d;
      pg_q    <= pg_d;
      pb_q    <= pb_d;
      gray_q  <= gray_d;
      done_q  <= done_d;
      fdone_q <= fdone_d;
    end
  end

  assign px.byte_ready  = (state_q == S_RUN);
  assign px.grayscale_o = gray_q;
  assign px.done_o      = done_q;
  assign frame_done     = fdone_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_rgb_to_grayscale_stream.sv
// tb/tb_rgb_to_grayscale_stream.sv - scoreboard bench for rgb_to_grayscale_stream
module tb_rgb_to_grayscale_stream;

  logic       clk;
  logic       rst;
  logic [2:0] st;
  logic [2:0] vld;
  logic [7:0] din;
  logic [2:0] rdy;
  logic [2:0] done_w;
  logic [2:0] fd_w;
  logic [2:0] busy_w;
  logic [7:0] gray_w [3];
  int         cyc;
  int         n_checks;
  int         n_fail;

  typedef struct {
    logic [7:0] gray;
    logic       fd;
    int         cyc;
  } exp_t;

  exp_t exp_q [3][$];

  logic [7:0] t5 [9] = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'h55, 8'h55, 8'h55};

  rgb_to_grayscale_stream_if if0 ();
  rgb_to_grayscale_stream_if if1 ();
  rgb_to_grayscale_stream_if if2 ();

  assign if0.byte_valid = vld[0];
  assign if1.byte_valid = vld[1];
  assign if2.byte_valid = vld[2];
  assign if0.byte_in    = din;
  assign if1.byte_in    = din;
  assign if2.byte_in    = din;
  assign rdy[0]         = if0.byte_ready;
  assign rdy[1]         = if1.byte_ready;
  assign rdy[2]         = if2.byte_ready;
  assign done_w[0]      = if0.done_o;
  assign done_w[1]      = if1.done_o;
  assign done_w[2]      = if2.done_o;
  assign gray_w[0]      = if0.grayscale_o;
  assign gray_w[1]      = if1.grayscale_o;
  assign gray_w[2]      = if2.grayscale_o;

  rgb_to_grayscale_stream #(.NUM_PIXELS(1)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .px(if0.slave),
    .frame_done(fd_w[0]), .busy(busy_w[0])
  );
  rgb_to_grayscale_stream #(.NUM_PIXELS(2)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .px(if1.slave),
    .frame_done(fd_w[1]), .busy(busy_w[1])
  );
  rgb_to_grayscale_stream #(.NUM_PIXELS(4)) dut2 (
    .clk(clk), .rst(rst), .start(st[2]), .px(if2.slave),
    .frame_done(fd_w[2]), .busy(busy_w[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe from any instance pops that instance's scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (done_w[k] || fd_w[k]) begin
          if (exp_q[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_strobe dut%0d: done_o=%0d frame_done=%0d, expected no strobe (cycle %0d)",
                     k, done_w[k], fd_w[k], cyc);
          end else begin
            e = exp_q[k].pop_front();
            check($sformatf("done_o dut%0d", k), 32'(done_w[k]), 32'd1);
            check($sformatf("grayscale_o dut%0d", k), 32'(gray_w[k]), 32'(e.gray));
            check($sformatf("frame_done dut%0d", k), 32'(fd_w[k]), 32'(e.fd));
            check($sformatf("latency_cycle dut%0d", k), 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int k);
    st[k] = 1'b1;
    @(posedge clk);
    #1;
    st[k] = 1'b0;
  endtask

  // Presents one byte until accepted; acc_cyc is the cycle it was accepted in.
  task automatic send(input int k, input logic [7:0] b, output int acc_cyc);
    int n;
    logic r;
    n = 0;
    r = 1'b0;
    acc_cyc = 0;
    din = b;
    vld[k] = 1'b1;
    do begin
      @(negedge clk);
      r = rdy[k];
      acc_cyc = cyc;
      n++;
      @(posedge clk);
      #1;
    end while (!r && n < 20);
    vld[k] = 1'b0;
    if (!r) check($sformatf("send_timeout dut%0d", k), 32'(r), 32'd1);
  endtask

  task automatic pixel(input int k, input logic [7:0] b, input logic [7:0] g, input logic [7:0] r,
                       input logic [7:0] gray, input logic fd, input bit bub);
    int c;
    exp_t e;
    send(k, b, c);
    if (bub) gap($urandom_range(0, 3));
    send(k, g, c);
    if (bub) gap($urandom_range(0, 3));
    send(k, r, c);
    e.gray = gray;
    e.fd   = fd;
    e.cyc  = c + 2;
    exp_q[k].push_back(e);
    if (bub) gap($urandom_range(0, 3));
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (exp_q[k].size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain dut%0d", k), 32'(exp_q[k].size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check($sformatf("busy_idle dut%0d", k), 32'(busy_w[k]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int acc;
    exp_t e;
    logic [8:0] rlog;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    st  = 3'b000;
    vld = 3'b000;
    din = 8'd0;
    gap(3);

    // Reset values.
    @(negedge clk);
    check("reset grayscale_o", 32'(gray_w[2]), 32'd0);
    check("reset done_o", 32'(done_w[2]), 32'd0);
    check("reset frame_done", 32'(fd_w[2]), 32'd0);
    check("reset byte_ready", 32'(rdy[2]), 32'd0);
    check("reset busy", 32'(busy_w), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    gap(2);

    // Reset asserted with a pixel in flight: nothing may emerge afterwards.
    pulse_start(2);
    check("busy after start", 32'(busy_w[2]), 32'd1);
    send(2, 8'd10, c);
    send(2, 8'd20, c);
    send(2, 8'd30, c);
    rst = 1'b1;
    @(negedge clk);
    check("midreset done_o", 32'(done_w[2]), 32'd0);
    check("midreset busy", 32'(busy_w[2]), 32'd0);
    gap(2);
    rst = 1'b0;
    vld[2] = 1'b1;
    din = 8'hAA;
    repeat (5) begin
      @(negedge clk);
      check("post-reset byte_ready", 32'(rdy[2]), 32'd0);
      check("post-reset grayscale_o", 32'(gray_w[2]), 32'd0);
    end
    @(posedge clk);
    #1;
    vld[2] = 1'b0;

    // Single-pixel frame, exact latency and busy fall.
    pulse_start(0);
    send(0, 8'd0, c);
    send(0, 8'd0, c);
    send(0, 8'd255, c);
    e.gray = 8'd77;
    e.fd   = 1'b1;
    e.cyc  = c + 2;
    exp_q[0].push_back(e);
    @(negedge clk);
    while (cyc < c + 2) @(negedge clk);
    check("single busy during done", 32'(busy_w[0]), 32'd1);
    @(negedge clk);
    check("single busy after done", 32'(busy_w[0]), 32'd0);
    drain(0);

    // Primary colours, gap-free.
    pulse_start(2);
    pixel(2, 8'd0,   8'd255, 8'd0,   8'd149, 1'b0, 1'b0);
    pixel(2, 8'd255, 8'd0,   8'd0,   8'd29,  1'b0, 1'b0);
    pixel(2, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 1'b0);
    pixel(2, 8'd0,   8'd0,   8'd0,   8'd0,   1'b1, 1'b0);
    drain(2);

    // Same pixels with random bubbles between bytes.
    pulse_start(2);
    pixel(2, 8'd0,   8'd255, 8'd0,   8'd149, 1'b0, 1'b1);
    pixel(2, 8'd255, 8'd0,   8'd0,   8'd29,  1'b0, 1'b1);
    pixel(2, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 1'b1);
    pixel(2, 8'd0,   8'd0,   8'd0,   8'd0,   1'b1, 1'b1);
    drain(2);

    // Frame boundary: 9 bytes offered, only 6 taken.
    pulse_start(1);
    acc  = 0;
    rlog = '0;
    for (int i = 0; i < 9; i++) begin
      din    = t5[i];
      vld[1] = 1'b1;
      @(negedge clk);
      rlog[i] = rdy[1];
      if (rdy[1]) begin
        acc++;
        if (acc == 3 || acc == 6) begin
          e.gray = (acc == 3) ? 8'd149 : 8'd29;
          e.fd   = (acc == 6);
          e.cyc  = cyc + 2;
          exp_q[1].push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    vld[1] = 1'b0;
    check("boundary bytes accepted", 32'(acc), 32'd6);
    check("boundary ready on byte 6", 32'(rlog[5]), 32'd1);
    check("boundary ready after byte 6", 32'(rlog[6]), 32'd0);
    drain(1);

    // start pulses mid-frame must not restart the count or byte index.
    pulse_start(2);
    pixel(2, 8'd10, 8'd20, 8'd30, 8'd22, 1'b0, 1'b0);
    send(2, 8'd100, c);
    pulse_start(2);
    check("start ignored busy", 32'(busy_w[2]), 32'd1);
    send(2, 8'd50, c);
    send(2, 8'd200, c);
    e.gray = 8'd101;
    e.fd   = 1'b0;
    e.cyc  = c + 2;
    exp_q[2].push_back(e);
    send(2, 8'd200, c);
    send(2, 8'd100, c);
    pulse_start(2);
    send(2, 8'd50, c);
    e.gray = 8'd96;
    e.fd   = 1'b0;
    e.cyc  = c + 2;
    exp_q[2].push_back(e);
    pixel(2, 8'd1, 8'd2, 8'd3, 8'd2, 1'b1, 1'b0);
    drain(2);

    gap(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
